// File: rtl/cost_func_unit_pkg.sv
// Shared constants for the cost function unit: fixed-point
// format, PLAN sigmoid breakpoints/offsets and FSM encodings.
package cost_func_unit_pkg;

  localparam int QN = 6;
  localparam int QM = 11;
  localparam int BITWIDTH = QN + QM + 1;
  localparam int ONE_Q = 1 << QM;

  localparam int PLAN_BP_SAT = 10240;
  localparam int PLAN_BP_HI = 4864;
  localparam int PLAN_BP_LO = 2048;

  localparam int PLAN_OFF_HI = 1728;
  localparam int PLAN_OFF_MID = 1280;
  localparam int PLAN_OFF_LO = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIG   = 3'd1,
    ST_SQR   = 3'd2,
    ST_GAP   = 3'd3,
    ST_PULSE = 3'd4
  } state_e;

endpackage

// File: rtl/cost_func_unit_sigmoid_plan.sv
// sigmoid_plan: combinational PLAN sigmoid approximation.
// Ports: x (signed Q.QM in), s (unsigned Q0.QM out, 0..ONE_Q).
module sigmoid_plan
  import cost_func_unit_pkg::*;
#(
  parameter int XW = BITWIDTH,
  parameter int SW = QM + 1
) (
  input  logic [XW-1:0] x,
  output logic [SW-1:0] s
);

  logic          neg;
  logic [XW-1:0] a;
  logic [SW-1:0] y;
  logic          in_sat;
  logic          in_hi;
  logic          in_mid;

  assign neg = x[XW-1];
  // Negating the most negative code wraps to itself; read as an
  // unsigned magnitude it is already past the saturation point.
  assign a = neg ? (~x + XW'(1)) : x;

  assign in_sat = (a >= XW'(PLAN_BP_SAT));
  assign in_hi  = !in_sat && (a >= XW'(PLAN_BP_HI));
  assign in_mid = !in_sat && !in_hi && (a >= XW'(PLAN_BP_LO));

  always_comb begin
    y = SW'(PLAN_OFF_LO) + SW'(a >> 2);
    unique case (1'b1)
      in_sat:  y = SW'(ONE_Q);
      in_hi:   y = SW'(PLAN_OFF_HI) + SW'(a >> 5);
      in_mid:  y = SW'(PLAN_OFF_MID) + SW'(a >> 3);
      default: y = SW'(PLAN_OFF_LO) + SW'(a >> 2);
    endcase
  end

  assign s = neg ? (SW'(ONE_Q) - y) : y;

endmodule

// File: rtl/cost_func_unit.sv
// cost_func_unit: sigmoid + squared-error cost with error counter.
// Ports: clock/reset, dataReadyP edge-triggered input capture,
// costFunc/newCostFunc result strobe, predBit, errCount, overrun.
module cost_func_unit #(
  parameter int QN = 6,
  parameter int QM = 11,
  parameter int BITWIDTH = QN + QM + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dataReadyP,
  input  logic [BITWIDTH-1:0] networkOutput,
  input  logic                modelOutput,
  input  logic                clrErr,
  output logic [BITWIDTH-1:0] costFunc,
  output logic                newCostFunc,
  output logic                predBit,
  output logic [15:0]         errCount,
  output logic                overrun
);

  import cost_func_unit_pkg::*;

  localparam int SW = QM + 1;
  localparam int EW = QM + 2;
  localparam int PW = 2 * EW;

  state_e               state_q;
  logic                 prev_q;
  logic                 armed_q;
  logic                 edge_q;
  logic                 edge_d;
  logic [BITWIDTH-1:0]  x_q;
  logic                 tgt_q;
  logic [SW-1:0]        s_d;
  logic [SW-1:0]        s_q;
  logic                 pred_q;
  logic                 strobe_q;
  logic                 ovr_q;
  logic [BITWIDTH-1:0]  cost_q;
  logic [BITWIDTH-1:0]  cost_d;
  logic [15:0]          err_cnt_q;
  logic signed [EW-1:0] err_d;
  logic signed [PW-1:0] sq_d;
  logic                 mism_d;

  sigmoid_plan #(
    .XW(BITWIDTH),
    .SW(SW)
  ) u_plan (
    .x(x_q),
    .s(s_d)
  );

  // armed_q blocks a level that was already high when reset
  // released from looking like a fresh rising edge.
  assign edge_d = dataReadyP & ~prev_q & armed_q;
  assign mism_d = pred_q ^ tgt_q;

  always_comb begin
    err_d = $signed({1'b0, tgt_q ? SW'(ONE_Q) : SW'(0)})
          - $signed({1'b0, s_q});
    sq_d = err_d * err_d;
    cost_d = BITWIDTH'(sq_d >> QM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      edge_q    <= 1'b0;
      x_q       <= '0;
      tgt_q     <= 1'b0;
      s_q       <= '0;
      pred_q    <= 1'b0;
      strobe_q  <= 1'b0;
      ovr_q     <= 1'b0;
      cost_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      prev_q   <= dataReadyP;
      armed_q  <= armed_q | ~dataReadyP;
      edge_q   <= edge_d;
      strobe_q <= 1'b0;

      if (edge_q && (state_q != ST_IDLE))
        ovr_q <= 1'b1;

      if (clrErr)
        err_cnt_q <= '0;
      else if ((state_q == ST_SQR) && mism_d)
        err_cnt_q <= err_cnt_q + 16'd1;

      unique case (state_q)
        ST_IDLE: begin
          if (edge_q) begin
            x_q     <= networkOutput;
            tgt_q   <= modelOutput;
            state_q <= ST_SIG;
          end
        end
        ST_SIG: begin
          s_q     <= s_d;
          pred_q  <= (s_d >= SW'(ONE_Q / 2));
          state_q <= ST_SQR;
        end
        ST_SQR: begin
          cost_q  <= cost_d;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          strobe_q <= 1'b1;
          state_q  <= ST_PULSE;
        end
        ST_PULSE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign costFunc    = cost_q;
  assign newCostFunc = strobe_q;
  assign predBit     = pred_q;
  assign errCount    = err_cnt_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_cost_func_unit.sv
// Directed bench for cost_func_unit: hand-computed
// sigmoid/cost vectors, handshake, counter and reset cases.
module tb_cost_func_unit;

  localparam int BW = 18;

  logic          clock;
  logic          reset;
  logic          dataReadyP;
  logic [BW-1:0] networkOutput;
  logic          modelOutput;
  logic          clrErr;
  logic [BW-1:0] costFunc;
  logic          newCostFunc;
  logic          predBit;
  logic [15:0]   errCount;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;

  cost_func_unit dut (
    .clock(clock),
    .reset(reset),
    .dataReadyP(dataReadyP),
    .networkOutput(networkOutput),
    .modelOutput(modelOutput),
    .clrErr(clrErr),
    .costFunc(costFunc),
    .newCostFunc(newCostFunc),
    .predBit(predBit),
    .errCount(errCount),
    .overrun(overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    reset = 1'b0;
    dataReadyP = 1'b0;
    clrErr = 1'b0;
    networkOutput = '0;
    modelOutput = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // One transaction; lat = posedges from raise to strobe, 0 = none.
  task automatic run_op(input logic [BW-1:0] x, input logic t,
                        output int lat);
    @(negedge clock);
    networkOutput = x;
    modelOutput = t;
    dataReadyP = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) dataReadyP = 1'b0;
      if (newCostFunc) begin
        lat = i;
        break;
      end
    end
  endtask

  // Bit i of pat/clrpat is driven at the i-th negedge.
  task automatic play(input logic [31:0] pat, input logic [31:0] clrpat,
                      input int n, input logic [BW-1:0] x2,
                      input logic t2, output int strobes,
                      output logic [BW-1:0] cost);
    strobes = 0;
    cost = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      dataReadyP = pat[i];
      clrErr = clrpat[i];
      if (i == 2) begin
        networkOutput = x2;
        modelOutput = t2;
      end
      @(posedge clock);
      #1;
      if (newCostFunc) begin
        strobes++;
        cost = costFunc;
      end
    end
    @(negedge clock);
    dataReadyP = 1'b0;
    clrErr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dataReadyP = 1'b0;
    clrErr = 1'b0;
    networkOutput = '0;
    modelOutput = 1'b0;
    #12;
    n_cmp++; if (costFunc !== '0) begin n_bad++; $display("FAIL rst_cost got %0d want 0", costFunc); end
    n_cmp++; if (newCostFunc !== 1'b0) begin n_bad++; $display("FAIL rst_strobe got %b want 0", newCostFunc); end
    n_cmp++; if (predBit !== 1'b0) begin n_bad++; $display("FAIL rst_pred got %b want 0", predBit); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL rst_err got %0d want 0", errCount); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_ovr got %b want 0", overrun); end
    do_reset();
  endtask

  task automatic test_zero();
    int lat;
    run_op(BW'(0), 1'b1, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL zero_lat got %0d want 5", lat); end
    n_cmp++; if (costFunc !== BW'(512)) begin n_bad++; $display("FAIL zero_cost got %0d want 512", costFunc); end
    n_cmp++; if (predBit !== 1'b1) begin n_bad++; $display("FAIL zero_pred got %b want 1", predBit); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL zero_err got %0d want 0", errCount); end
    @(posedge clock);
    #1;
    n_cmp++; if (newCostFunc !== 1'b0) begin n_bad++; $display("FAIL zero_strobe_width got %b want 0", newCostFunc); end
  endtask

  task automatic test_vectors();
    int tx[12] = '{10240, -2048, 4864, 2047, 2048, 10239,
                   4863, -1, -131072, -131072, -10240, -4864};
    logic tt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int tc[12] = '{2048, 128, 13, 128, 128, 0,
                   1738, 512, 0, 2048, 2048, 13};
    logic tp[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    logic [15:0] exp_err;
    do_reset();
    exp_err = 16'd0;
    for (int i = 0; i < 12; i++) begin
      run_op(BW'(tx[i]), tt[i], lat);
      if (tp[i] != tt[i]) exp_err = exp_err + 16'd1;
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL vec%0d_lat got %0d want 5", i, lat); end
      n_cmp++; if (costFunc !== BW'(tc[i])) begin n_bad++; $display("FAIL vec%0d_cost got %0d want %0d", i, costFunc, tc[i]); end
      n_cmp++; if (predBit !== tp[i]) begin n_bad++; $display("FAIL vec%0d_pred got %b want %b", i, predBit, tp[i]); end
      n_cmp++; if (errCount !== exp_err) begin n_bad++; $display("FAIL vec%0d_err got %0d want %0d", i, errCount, exp_err); end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [BW-1:0] c;
    do_reset();
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr_pre got %b want 0", overrun); end
    networkOutput = BW'(0);
    modelOutput = 1'b1;
    play(32'h5, 32'h0, 16, BW'(10240), 1'b0, s, c);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL b2b_strobes got %0d want 1", s); end
    n_cmp++; if (c !== BW'(512)) begin n_bad++; $display("FAIL b2b_cost got %0d want 512", c); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_ovr got %b want 1", overrun); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL b2b_err got %0d want 0", errCount); end
  endtask

  task automatic test_pulse_drop();
    int s;
    int lat;
    logic [BW-1:0] c;
    do_reset();
    networkOutput = BW'(0);
    modelOutput = 1'b1;
    play(32'h11, 32'h0, 16, BW'(10240), 1'b0, s, c);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL pulse_strobes got %0d want 1", s); end
    n_cmp++; if (c !== BW'(512)) begin n_bad++; $display("FAIL pulse_cost got %0d want 512", c); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL pulse_ovr got %b want 1", overrun); end
    run_op(-BW'(2048), 1'b0, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL pulse_next_lat got %0d want 5", lat); end
    n_cmp++; if (costFunc !== BW'(128)) begin n_bad++; $display("FAIL pulse_next_cost got %0d want 128", costFunc); end
  endtask

  task automatic test_held_level();
    int s;
    logic [BW-1:0] c;
    do_reset();
    networkOutput = -BW'(2048);
    modelOutput = 1'b0;
    play(32'h000F_FFFF, 32'h0, 30, -BW'(2048), 1'b0, s, c);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL held_strobes got %0d want 1", s); end
    n_cmp++; if (c !== BW'(128)) begin n_bad++; $display("FAIL held_cost got %0d want 128", c); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL held_ovr got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int s;
    int lat;
    logic [BW-1:0] c;
    do_reset();
    run_op(BW'(10240), 1'b0, lat);
    n_cmp++; if (costFunc !== BW'(2048)) begin n_bad++; $display("FAIL mid_pre_cost got %0d want 2048", costFunc); end
    @(negedge clock);
    networkOutput = BW'(0);
    modelOutput = 1'b1;
    dataReadyP = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (costFunc !== '0) begin n_bad++; $display("FAIL mid_cost got %0d want 0", costFunc); end
    n_cmp++; if (newCostFunc !== 1'b0) begin n_bad++; $display("FAIL mid_strobe got %b want 0", newCostFunc); end
    n_cmp++; if (predBit !== 1'b0) begin n_bad++; $display("FAIL mid_pred got %b want 0", predBit); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL mid_err got %0d want 0", errCount); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL mid_ovr got %b want 0", overrun); end
    @(negedge clock);
    reset = 1'b1;
    play(32'h3FF, 32'h0, 10, BW'(0), 1'b1, s, c);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL mid_held_strobes got %0d want 0", s); end
    run_op(BW'(0), 1'b1, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL mid_rearm_lat got %0d want 5", lat); end
    n_cmp++; if (costFunc !== BW'(512)) begin n_bad++; $display("FAIL mid_rearm_cost got %0d want 512", costFunc); end
  endtask

  task automatic test_err_wrap();
    int lat;
    do_reset();
    @(negedge clock);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.err_cnt_q;
    #1;
    n_cmp++; if (errCount !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre got %h want ffff", errCount); end
    run_op(BW'(10240), 1'b0, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wrap_lat got %0d want 5", lat); end
    n_cmp++; if (errCount !== 16'h0000) begin n_bad++; $display("FAIL wrap_err got %h want 0000", errCount); end
  endtask

  task automatic test_clr_coincident();
    int s;
    int lat;
    logic [BW-1:0] c;
    do_reset();
    run_op(BW'(10240), 1'b0, lat);
    n_cmp++; if (errCount !== 16'd1) begin n_bad++; $display("FAIL clr_pre got %0d want 1", errCount); end
    networkOutput = BW'(10240);
    modelOutput = 1'b0;
    play(32'h1, 32'h8, 12, BW'(10240), 1'b0, s, c);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL clr_strobes got %0d want 1", s); end
    n_cmp++; if (errCount !== 16'd0) begin n_bad++; $display("FAIL clr_err got %0d want 0", errCount); end
    run_op(BW'(10240), 1'b0, lat);
    n_cmp++; if (errCount !== 16'd1) begin n_bad++; $display("FAIL clr_after got %0d want 1", errCount); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_back_to_back();
    test_pulse_drop();
    test_held_level();
    test_reset_mid();
    test_err_wrap();
    test_clr_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
